wallace_pipelined_multiplier: RTL and testbench
===============================================

Name: wallace_pipelined_multiplier

Overview:
- Parametrised, pipelined Wallace-tree multiplier for WIDTH x WIDTH operands with per-transaction signed/unsigned mode.
- Successor to the fixed-width combinational Wallace multipliers.
- Valid/ready handshake on both sides; full throughput of one product per cycle; whole-pipeline stall on output backpressure.
- Sits between operand producers (datapath/DSP front end) and result consumers.

Parameters:
- WIDTH, 8, operand width in bits; legal 4..32.
- PIPE_STAGES, 3, register stages from accept to result; legal 1..4.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- is_signed  input  1  1 = two's-complement a and b; 0 = unsigned.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  exact full-width product.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low (clk, rst_n). While rst_n=0 at a rising edge, all stage valid bits, out_valid, product and internal data registers clear to 0.
- in_ready is combinational: advance = !out_valid || out_ready; in_ready = advance. After reset in_ready=1.
- Accept: transfer occurs when in_valid && in_ready. a, b and is_signed are captured together. is_signed applies only to its own beat, so mixed modes may be back-to-back.
- Pipeline: PIPE_STAGES register ranks, each holding a valid bit and data.
  - All ranks shift together when advance=1 and hold when advance=0.
  - Bubbles are carried, not collapsed.
  - Rank 1 follows partial-product generation and the first reduction layers. The final rank follows the carry-propagate adder and drives product/out_valid directly.
  - Intermediate ranks are placed at balanced points across reduction layers.
- Latency: exactly PIPE_STAGES cycles from accept edge to out_valid=1 with no stall. Stalls add cycles 1:1.
- Arithmetic:
  - Partial products pp[i][j] = a[j]&b[i].
  - Signed mode uses Baugh-Wooley: invert the MSB-row/MSB-column partial products and add constant 1 at columns WIDTH and 2*WIDTH-1.
  - Reduction uses 3:2 full adders and 2:2 half adders per Wallace rules, then a ripple or prefix final adder.
  - Result is exact modulo 2^(2*WIDTH); no overflow is possible.
- Output hold: product and out_valid stay stable while out_valid && !out_ready.
- Simultaneous consume and accept: in one cycle the final rank is replaced and a new beat enters rank 1.
- Reset mid-operation: all in-flight beats are discarded; no partial output appears after reset.
- Invalid ranks: data is don't-care internally. product is only meaningful when out_valid=1, but holds its last value otherwise.

Optional Feature:
- Macro: WALLACE_MAC_ACC_EN.
- Defined:
  - Adds input acc_clr (1) and output acc_out (2*WIDTH+8).
  - On each output handshake (out_valid && out_ready), acc_out <= (acc_clr ? 0 : acc_out) + sign/zero-extended product. Extension follows that beat's is_signed, which is carried down the pipeline.
  - acc_clr without a handshake sets acc_out to 0.
  - Accumulation wraps modulo 2^(2*WIDTH+8).
  - Reset clears acc_out to 0.
  - Pipeline latency is unchanged.
- Undefined: ports and logic are absent; core behaviour is identical.

Test Plan (WIDTH=8, PIPE_STAGES=3):
1. Unsigned corners: (0,0), (255,255), (1,200), driven back-to-back with out_ready=1 -> products 0x0000, 0xFE01, 0x00C8 on three consecutive cycles, first one 3 cycles after its accept.
2. Signed corners: (-128,-128), (-1,1), (127,-128), (-1,-1) -> 0x4000, 0xFFFF, 0xC080, 0x0001.
3. Mixed mode back-to-back: a=0xFF, b=0x02 unsigned then signed -> 0x01FE then 0xFFFE, in order.
4. Backpressure: fill pipeline, hold out_ready=0 for 5 cycles -> in_ready=0, product frozen, no beat lost or duplicated. Release -> remaining results in order, one per cycle.
5. Reset mid-stream: 2 beats in flight, assert rst_n=0 for one edge -> out_valid=0, product=0; no stale result ever appears.
6. Random 10k beats, random in_valid/out_ready, compared against a reference model. With WALLACE_MAC_ACC_EN: 4 signed beats of (-1,1) after acc_clr -> acc_out = 2^24-4.

Source files
------------

// File: rtl/wallace_pipelined_multiplier.sv
// Pipelined Wallace-tree multiplier with per-beat signed (Baugh-Wooley) or unsigned mode.
// Optional accumulator enabled by defining WALLACE_MAC_ACC_EN.
module wallace_pipelined_multiplier #(
    parameter int WIDTH       = 8,
    parameter int PIPE_STAGES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef WALLACE_MAC_ACC_EN
    input  logic                 acc_clr,
    output logic [2*WIDTH+7:0]   acc_out,
`endif
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW   = 2 * WIDTH;
    localparam int MAXH = WIDTH + 1;

    // Bit heap: MAXH rows of PW-bit weighted vectors; rows past the live height are zero.
    typedef logic [MAXH-1:0][PW-1:0] heap_t;

    function automatic int next_height(input int h);
        return 2 * (h / 3) + (h % 3);
    endfunction

    function automatic int height_at(input int k);
        int h;
        h = MAXH;
        for (int i = 0; i < k; i++) begin
            h = next_height(h);
        end
        return h;
    endfunction

    function automatic int num_layers(input int h0);
        int h;
        int n;
        h = h0;
        n = 0;
        while (h > 2) begin
            h = next_height(h);
            n++;
        end
        return n;
    endfunction

    localparam int NL = num_layers(MAXH);

    // Ranks 1..PIPE_STAGES-1 sit after evenly spread reduction layers; the last always after layer NL.
    function automatic logic is_cut(input int k);
        for (int r = 1; r < PIPE_STAGES; r++) begin
            if ((r * NL) / (PIPE_STAGES - 1) == k) begin
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [PW-1:0] carry_shift(input logic [PW-1:0] v);
        return v << 1'b1;
    endfunction

    // One Wallace layer: 3:2 on each full triple, 2:2 on a leftover pair, single leftover passes.
    function automatic heap_t reduce_layer(input heap_t hi, input int h);
        heap_t         ho;
        logic [PW-1:0] x;
        logic [PW-1:0] y;
        logic [PW-1:0] z;
        int            g;
        int            r;
        int            s;
        ho = '0;
        x  = '0;
        y  = '0;
        z  = '0;
        g  = h / 3;
        r  = h % 3;
        s  = g + ((r != 0) ? 1 : 0);
        for (int k = 0; k < MAXH / 3; k++) begin
            if (k < g) begin
                x         = hi[3*k];
                y         = hi[3*k+1];
                z         = hi[3*k+2];
                ho[k]     = x ^ y ^ z;
                ho[s + k] = carry_shift((x & y) | (x & z) | (y & z));
            end
        end
        if (r == 2) begin
            x         = hi[3*g];
            y         = hi[3*g+1];
            ho[g]     = x ^ y;
            ho[s + g] = carry_shift(x & y);
        end else if (r == 1) begin
            ho[g] = hi[3*g];
        end
        return ho;
    endfunction

    function automatic logic [PW-1:0] final_add(input heap_t h);
        return h[0] + h[1];
    endfunction

    logic                   advance_s;
    logic [PIPE_STAGES:1]   vld_r;
    logic [PIPE_STAGES-1:0] vld_feed_s;
    logic [PW-1:0]          product_r;
    heap_t                  heap0_s;
    heap_t                  stage_heap_s [NL+1];

    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s;
    assign out_valid = vld_r[PIPE_STAGES];
    assign product   = product_r;

    // Partial products; signed mode inverts the off-corner MSB row/column terms and adds 2^W + 2^(2W-1).
    always_comb begin
        heap0_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                heap0_s[i][i+j] = (a[j] & b[i]) ^ (is_signed & ((i == WIDTH - 1) != (j == WIDTH - 1)));
            end
        end
        if (is_signed) begin
            heap0_s[WIDTH][WIDTH] = 1'b1;
            heap0_s[WIDTH][PW-1]  = 1'b1;
        end else begin
            heap0_s[WIDTH] = '0;
        end
    end

    assign stage_heap_s[0] = heap0_s;

    for (genvar k = 1; k <= NL; k++) begin : g_layer
        localparam int HIN = height_at(k - 1);
        heap_t dcomb_s;

        assign dcomb_s = reduce_layer(stage_heap_s[k-1], HIN);

        if (is_cut(k)) begin : g_rank
            heap_t dreg_r;

            // Data rank after this layer; bubbles load don't-care data.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dreg_r <= '0;
                end else if (advance_s) begin
                    dreg_r <= dcomb_s;
                end
            end

            assign stage_heap_s[k] = dreg_r;
        end else begin : g_pass
            assign stage_heap_s[k] = dcomb_s;
        end
    end

`ifdef WALLACE_MAC_ACC_EN
    logic [PIPE_STAGES:1]   sgn_r;
    logic [PIPE_STAGES-1:0] sgn_feed_s;
`endif

    if (PIPE_STAGES == 1) begin : g_feed_one
        assign vld_feed_s = in_valid;
`ifdef WALLACE_MAC_ACC_EN
        assign sgn_feed_s = is_signed;
`endif
    end else begin : g_feed_many
        assign vld_feed_s = {vld_r[PIPE_STAGES-1:1], in_valid};
`ifdef WALLACE_MAC_ACC_EN
        assign sgn_feed_s = {sgn_r[PIPE_STAGES-1:1], is_signed};
`endif
    end

    // Valid bits shift in lockstep with the data ranks, carrying bubbles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_r <= '0;
        end else if (advance_s) begin
            vld_r <= vld_feed_s;
        end
    end

    // Final rank: carry-propagate add; only a valid beat replaces the held product.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            product_r <= '0;
        end else if (advance_s && vld_feed_s[PIPE_STAGES-1]) begin
            product_r <= final_add(stage_heap_s[NL]);
        end
    end

`ifdef WALLACE_MAC_ACC_EN
    logic [PW+7:0] acc_r;
    logic [PW+7:0] acc_ext_s;

    assign acc_ext_s = {{8{sgn_r[PIPE_STAGES] & product_r[PW-1]}}, product_r};
    assign acc_out   = acc_r;

    // Per-beat mode travels with the beat so the accumulator can extend correctly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sgn_r <= '0;
        end else if (advance_s) begin
            sgn_r <= sgn_feed_s;
        end
    end

    // Accumulate each delivered product; acc_clr restarts from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r <= '0;
        end else if (out_valid && out_ready) begin
            acc_r <= (acc_clr ? '0 : acc_r) + acc_ext_s;
        end else if (acc_clr) begin
            acc_r <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_wallace_pipelined_multiplier.sv
// Directed and randomised self-checking bench for wallace_pipelined_multiplier (WIDTH=8, PIPE_STAGES=3).
module tb_wallace_pipelined_multiplier;

    localparam int W = 8;
    localparam int P = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   product;
`ifdef WALLACE_MAC_ACC_EN
    logic             acc_clr;
    logic [2*W+7:0]   acc_out;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    wallace_pipelined_multiplier #(.WIDTH(W), .PIPE_STAGES(P)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef WALLACE_MAC_ACC_EN
        .acc_clr   (acc_clr),
        .acc_out   (acc_out),
`endif
        .product   (product)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [2*W-1:0] ex;
        logic [2*W-1:0] ey;
        if (s) begin
            ex = {{W{x[W-1]}}, x};
            ey = {{W{y[W-1]}}, y};
        end else begin
            ex = {{W{1'b0}}, x};
            ey = {{W{1'b0}}, y};
        end
        return ex * ey;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; is_signed = 1'b0;
`ifdef WALLACE_MAC_ACC_EN
        acc_clr = 1'b0;
`endif
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else n_pass++;
        n_total++;
        if (product !== 16'h0000) $display("FAIL reset_product got=%h want=0000", product); else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else n_pass++;
    endtask

    task automatic test_unsigned();
        logic [W-1:0]   va [3] = '{8'd0, 8'd255, 8'd1};
        logic [W-1:0]   vb [3] = '{8'd0, 8'd255, 8'd200};
        logic [2*W-1:0] ve [3] = '{16'h0000, 16'hFE01, 16'h00C8};
        out_ready = 1'b1; is_signed = 1'b0;
        for (int i = 0; i < 3 + P - 1; i++) begin
            if (i < 3) begin in_valid = 1'b1; a = va[i]; b = vb[i]; end else in_valid = 1'b0;
            tick();
            n_total++;
            if (i < P - 1) begin
                if (out_valid !== 1'b0) $display("FAIL uns_latency cyc=%0d got valid=%b want=0", i, out_valid); else n_pass++;
            end else begin
                if (out_valid !== 1'b1 || product !== ve[i-(P-1)])
                    $display("FAIL uns_product beat=%0d got valid=%b prod=%h want valid=1 prod=%h", i-(P-1), out_valid, product, ve[i-(P-1)]);
                else n_pass++;
            end
        end
        tick();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL uns_drain got valid=%b want=0", out_valid); else n_pass++;
    endtask

    task automatic test_signed();
        logic [W-1:0]   va [4] = '{8'h80, 8'hFF, 8'h7F, 8'hFF};
        logic [W-1:0]   vb [4] = '{8'h80, 8'h01, 8'h80, 8'hFF};
        logic [2*W-1:0] ve [4] = '{16'h4000, 16'hFFFF, 16'hC080, 16'h0001};
        out_ready = 1'b1; is_signed = 1'b1;
        for (int i = 0; i < 4 + P - 1; i++) begin
            if (i < 4) begin in_valid = 1'b1; a = va[i]; b = vb[i]; end else in_valid = 1'b0;
            tick();
            if (i >= P - 1) begin
                n_total++;
                if (out_valid !== 1'b1 || product !== ve[i-(P-1)])
                    $display("FAIL sgn_product beat=%0d got valid=%b prod=%h want valid=1 prod=%h", i-(P-1), out_valid, product, ve[i-(P-1)]);
                else n_pass++;
            end
        end
        tick();
    endtask

    task automatic test_mixed();
        logic           vs [2] = '{1'b0, 1'b1};
        logic [2*W-1:0] ve [2] = '{16'h01FE, 16'hFFFE};
        out_ready = 1'b1; a = 8'hFF; b = 8'h02;
        for (int i = 0; i < 2 + P - 1; i++) begin
            if (i < 2) begin in_valid = 1'b1; is_signed = vs[i]; end else in_valid = 1'b0;
            tick();
            if (i >= P - 1) begin
                n_total++;
                if (out_valid !== 1'b1 || product !== ve[i-(P-1)])
                    $display("FAIL mixed_product beat=%0d got valid=%b prod=%h want valid=1 prod=%h", i-(P-1), out_valid, product, ve[i-(P-1)]);
                else n_pass++;
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [W-1:0]   va [4] = '{8'd3, 8'd200, 8'd17, 8'd250};
        logic [W-1:0]   vb [4] = '{8'd5, 8'd100, 8'd19, 8'd2};
        logic [2*W-1:0] ve [4] = '{16'h000F, 16'h4E20, 16'h0143, 16'h01F4};
        out_ready = 1'b1; is_signed = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = va[i]; b = vb[i];
            tick();
        end
        a = va[3]; b = vb[3]; out_ready = 1'b0;
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b want=0", in_ready); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_total++;
            if (out_valid !== 1'b1 || product !== ve[0] || in_ready !== 1'b0)
                $display("FAIL bp_hold cyc=%0d got valid=%b prod=%h rdy=%b want valid=1 prod=%h rdy=0", c, out_valid, product, in_ready, ve[0]);
            else n_pass++;
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            in_valid = 1'b0;
            n_total++;
            if (out_valid !== 1'b1 || product !== ve[i])
                $display("FAIL bp_release beat=%0d got valid=%b prod=%h want valid=1 prod=%h", i, out_valid, product, ve[i]);
            else n_pass++;
        end
        tick();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL bp_drain got valid=%b want=0", out_valid); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1; is_signed = 1'b0;
        in_valid = 1'b1; a = 8'd9;  b = 8'd9;  tick();
        a = 8'd10; b = 8'd10; tick();
        in_valid = 1'b0; rst_n = 1'b0;
        tick();
        n_total++;
        if (out_valid !== 1'b0 || product !== 16'h0000)
            $display("FAIL rst_mid got valid=%b prod=%h want valid=0 prod=0000", out_valid, product);
        else n_pass++;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_total++;
            if (out_valid !== 1'b0) $display("FAIL rst_stale cyc=%0d got valid=%b want=0", c, out_valid); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [2*W-1:0] q [$];
        logic [2*W-1:0] exp_v;
        int sent   = 0;
        int got    = 0;
        int cycles = 0;
        while (got < 10000 && cycles < 80000) begin
            in_valid  = (sent < 10000) && ($urandom_range(3) != 0);
            a         = W'($urandom);
            b         = W'($urandom);
            is_signed = 1'($urandom_range(1));
            out_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                q.push_back(ref_mul(a, b, is_signed));
                sent++;
            end
            if (out_valid && out_ready) begin
                n_total++;
                if (q.size() == 0) begin
                    $display("FAIL rand_spurious got prod=%h want no output", product);
                end else begin
                    exp_v = q.pop_front();
                    if (product !== exp_v) $display("FAIL rand_product n=%0d got=%h want=%h", got, product, exp_v);
                    else n_pass++;
                end
                got++;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_total++;
        if (got != 10000 || q.size() != 0) $display("FAIL rand_count got=%0d want=10000 pending=%0d", got, q.size());
        else n_pass++;
        repeat (P + 1) tick();
    endtask

`ifdef WALLACE_MAC_ACC_EN
    task automatic test_mac();
        out_ready = 1'b1; in_valid = 1'b0; acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        n_total++;
        if (acc_out !== 24'h000000) $display("FAIL mac_clear got=%h want=000000", acc_out); else n_pass++;
        is_signed = 1'b1; a = 8'hFF; b = 8'h01;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        repeat (P + 2) tick();
        n_total++;
        if (acc_out !== 24'hFFFFFC) $display("FAIL mac_acc got=%h want=fffffc", acc_out); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_mixed();
        test_backpressure();
        test_reset_midstream();
        test_random();
`ifdef WALLACE_MAC_ACC_EN
        test_mac();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
